resp_capture: RTL and testbench
===============================

RESP_CAPTURE -- requirements
Module: resp_capture

Interface
REQ-001 Parameter WIDTH, default 2, bit width of one captured response sample (Y2:Y1).
REQ-002 Parameter DEPTH, default 8, sample buffer depth in entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that arms a capture run.
REQ-006 capture_len  input  8  number of samples to accept per run; sampled on start.
REQ-007 in_valid  input  1  response sample present on in_y.
REQ-008 in_y  input  WIDTH  response sample from the unit under test.
REQ-009 in_ready  output  1  block accepts in_y this cycle.
REQ-010 out_valid  output  1  buffered sample available on out_y.
REQ-011 out_y  output  WIDTH  oldest buffered sample (first-word fall-through).
REQ-012 out_ready  input  1  downstream consumes out_y this cycle.
REQ-013 level  output  $clog2(DEPTH)+1  current buffer occupancy, 0..DEPTH.
REQ-014 done  output  1  high while the state is DONE.
REQ-015 overflow  output  1  sticky; a sample was offered while the buffer was full.

Function
REQ-016 States SHALL be IDLE, CAPTURE and DONE.
REQ-017 From IDLE or DONE, start SHALL go to CAPTURE and load remaining=capture_len; if capture_len=0, it SHALL go to DONE instead.
REQ-018 In CAPTURE, start SHALL be ignored.
REQ-019 Write: in_valid && in_ready SHALL store in_y at the tail in the same edge and decrement remaining.
REQ-020 A write with remaining=1 SHALL move the state to DONE on that edge.
REQ-021 in_ready SHALL be (state==CAPTURE) && (level<DEPTH), combinational from registered state only.
REQ-022 Read: out_valid && out_ready SHALL pop the head; out_valid SHALL be (level!=0) in every state.
REQ-023 Simultaneous read and write SHALL leave level unchanged.
REQ-024 When full, in_ready SHALL be 0 even if a read occurs in the same cycle; no write-through.
REQ-025 in_valid in CAPTURE with level=DEPTH SHALL set overflow; the sample is dropped and remaining is unchanged.
REQ-026 overflow SHALL be cleared only by reset or by a start that is accepted.
REQ-027 Pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow below 0.
REQ-028 Buffer contents SHALL persist across DONE and across a new start.
REQ-029 Write-to-out_valid latency SHALL be 1 cycle when the buffer is empty.

Reset
REQ-030 Asserting rst_n low SHALL force state=IDLE, pointers=0, level=0, remaining=0, overflow=0, in_ready=0, out_valid=0 and done=0, including mid-run.
REQ-031 out_y SHALL be all zeros while level=0 after reset; stored buffer data is not reset.

Configuration
REQ-032 Macro RESP_CAPTURE_CMP_EN SHALL add input exp_y (WIDTH) and output mismatch_cnt (8 bits).
REQ-033 With RESP_CAPTURE_CMP_EN, each write with in_y!=exp_y SHALL increment mismatch_cnt, saturating at 255; mismatch_cnt resets to 0 on reset or on an accepted start.
REQ-034 Without RESP_CAPTURE_CMP_EN, neither port nor any comparison logic SHALL exist.

Structure
REQ-035 A shared package/header SHALL hold the state encodings (IDLE=0, CAPTURE=1, DONE=2) and the default WIDTH and DEPTH values.
REQ-036 The buffer SHALL be a sub-module resp_fifo (mem, pointers, level, first-word fall-through).
REQ-037 The FSM, remaining counter, overflow flag and comparator SHALL be in resp_capture.

Verification
REQ-038 Reset, then start with capture_len=4 and samples 01,10,10,01 with out_ready=0 -> level=4, done=1, out_y=01.
REQ-039 Drain the buffer from REQ-038 with out_ready=1 -> out_y sequence 01,10,10,01, then out_valid=0 and level=0.
REQ-040 DEPTH=8, capture_len=10, out_ready=0, in_valid held high -> in_ready=0 after 8 writes, overflow=1, level=8, state CAPTURE.
REQ-041 Full buffer with in_valid=1 and out_ready=1 in the same cycle -> one pop, no push, level=7; the next cycle accepts a write.
REQ-042 Start with capture_len=0 -> done=1 on the next cycle and no write occurs; rst_n low mid-CAPTURE -> all outputs at reset values immediately.
REQ-043 With RESP_CAPTURE_CMP_EN, 4 samples with 2 differing from exp_y -> mismatch_cnt=2.

Source files
------------

// File: rtl/resp_capture_pkg.sv
// Shared definitions for the response capture block.
//   state_t    : capture FSM encoding (IDLE=0, CAPTURE=1, DONE=2)
//   DEF_WIDTH  : default sample width
//   DEF_DEPTH  : default sample buffer depth
package resp_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 2;
   localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/resp_capture_if.sv
// Sample stream handshake between the unit under test, the capture buffer
// and the downstream consumer.
//   in_valid / in_y / in_ready    : response samples into the buffer
//   out_valid / out_y / out_ready : buffered samples out (first-word fall-through)
// Modports: slave = capture block, master = driver/consumer side.
interface resp_capture_if
   import resp_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic [WIDTH-1:0] in_y;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_y;
   logic             out_ready;

   modport slave (
      input  in_valid, in_y, out_ready,
      output in_ready, out_valid, out_y
   );

   modport master (
      output in_valid, in_y, out_ready,
      input  in_ready, out_valid, out_y
   );
endinterface

// File: rtl/resp_capture_fifo.sv
// resp_fifo: first-word fall-through sample buffer.
// Ports:
//   clk, rst_n : clock, async active-low reset (pointers/level only)
//   push       : write wr_data at the tail (ignored when full)
//   wr_data    : sample to store
//   pop        : drop the head entry (ignored when empty)
//   rd_data    : head entry, all zeros while empty
//   level      : occupancy, 0..DEPTH
module resp_fifo
   import resp_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push && (level != LW'(DEPTH));
   assign pop_ok  = pop && (level != '0);

   // Storage is deliberately not reset; rd_data is masked while empty instead.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   assign rd_data = (level == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/resp_capture.sv
// resp_capture: arms on start, accepts capture_len response samples into a
// FIFO, flags samples offered while the FIFO is full.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   start         : one-cycle pulse arming a run (ignored while capturing)
//   capture_len   : samples to accept per run, sampled on start
//   bus (slave)   : in_valid/in_y/in_ready, out_valid/out_y/out_ready
//   level         : buffer occupancy
//   done          : high while in DONE
//   overflow      : sticky, sample offered while full
// Optional (macro RESP_CAPTURE_CMP_EN):
//   exp_y         : expected sample compared on every accepted write
//   mismatch_cnt  : saturating count of accepted samples differing from exp_y
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | after reset, waiting for start
// CAPTURE  | accepting samples until remaining reaches zero
// DONE     | run complete, buffer still drainable, start re-arms
module resp_capture
   import resp_capture_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [7:0]             capture_len,
   resp_capture_if.slave          bus,
`ifdef RESP_CAPTURE_CMP_EN
   input  logic [WIDTH-1:0]       exp_y,
   output logic [7:0]             mismatch_cnt,
`endif
   output logic [$clog2(DEPTH):0] level,
   output logic                   done,
   output logic                   overflow
);
   localparam int LW = $clog2(DEPTH) + 1;

   state_t     state;
   logic [7:0] remaining;
   logic       full;
   logic       wr_en;
   logic       rd_en;

   assign full          = (level == LW'(DEPTH));
   assign bus.in_ready  = (state == ST_CAPTURE) && !full;
   assign bus.out_valid = (level != '0);
   assign wr_en         = bus.in_valid && bus.in_ready;
   assign rd_en         = bus.out_valid && bus.out_ready;

   resp_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (wr_en),
      .wr_data (bus.in_y),
      .pop     (rd_en),
      .rd_data (bus.out_y),
      .level   (level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         remaining <= '0;
         overflow  <= 1'b0;
         done      <= 1'b0;
`ifdef RESP_CAPTURE_CMP_EN
         mismatch_cnt <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  overflow  <= 1'b0;
                  remaining <= capture_len;
`ifdef RESP_CAPTURE_CMP_EN
                  mismatch_cnt <= '0;
`endif
                  if (capture_len == 8'd0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_CAPTURE;
                     done  <= 1'b0;
                  end
               end
            end
            ST_CAPTURE: begin
               // A dropped sample (full buffer) does not consume remaining.
               if (bus.in_valid && full) overflow <= 1'b1;
               if (wr_en) begin
                  remaining <= remaining - 8'd1;
                  if (remaining == 8'd1) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
`ifdef RESP_CAPTURE_CMP_EN
                  if ((bus.in_y != exp_y) && (mismatch_cnt != 8'hFF))
                     mismatch_cnt <= mismatch_cnt + 8'd1;
`endif
               end
            end
            default: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_resp_capture.sv
// Directed bench for resp_capture (WIDTH=2, DEPTH=8). Inputs change 1 ns
// after the rising edge; outputs are checked at that same point.
module tb_resp_capture;
   import resp_capture_pkg::*;

   localparam int WIDTH = 2;
   localparam int DEPTH = 8;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] capture_len;
   logic [3:0] level;
   logic       done;
   logic       overflow;
`ifdef RESP_CAPTURE_CMP_EN
   logic [WIDTH-1:0] exp_y;
   logic [7:0]       mismatch_cnt;
`endif

   int n_checks;
   int n_fail;

   resp_capture_if #(.WIDTH(WIDTH)) bus ();

   resp_capture #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .capture_len  (capture_len),
      .bus          (bus.slave),
`ifdef RESP_CAPTURE_CMP_EN
      .exp_y        (exp_y),
      .mismatch_cnt (mismatch_cnt),
`endif
      .level        (level),
      .done         (done),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [7:0] len);
      start       = 1'b1;
      capture_len = len;
      tick();
      start       = 1'b0;
   endtask

   logic [1:0] seq_a [4];
   logic [1:0] seq_b [4];
   logic [1:0] seq_e [4];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      seq_a = '{2'b01, 2'b10, 2'b10, 2'b01};
      seq_b = '{2'b01, 2'b10, 2'b11, 2'b00};
      seq_e = '{2'b01, 2'b01, 2'b11, 2'b10};
      rst_n         = 1'b0;
      start         = 1'b0;
      capture_len   = 8'd0;
      bus.in_valid  = 1'b0;
      bus.in_y      = '0;
      bus.out_ready = 1'b0;
`ifdef RESP_CAPTURE_CMP_EN
      exp_y = '0;
`endif

      // Reset state
      #12;
      check_val("rst_level", 32'(level), 0);
      check_val("rst_out_valid", 32'(bus.out_valid), 0);
      check_val("rst_in_ready", 32'(bus.in_ready), 0);
      check_val("rst_done", 32'(done), 0);
      check_val("rst_overflow", 32'(overflow), 0);
      check_val("rst_out_y", 32'(bus.out_y), 0);
      #5 rst_n = 1'b1;
      tick();

      // Four-sample run, no draining
      pulse_start(8'd4);
      check_val("run4_in_ready", 32'(bus.in_ready), 1);
      check_val("run4_done0", 32'(done), 0);
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_y     = seq_a[i];
         tick();
         if (i == 0) begin
            check_val("first_out_valid", 32'(bus.out_valid), 1);
            check_val("first_out_y", 32'(bus.out_y), 32'h1);
         end
      end
      bus.in_valid = 1'b0;
      check_val("run4_level", 32'(level), 4);
      check_val("run4_done", 32'(done), 1);
      check_val("run4_out_y", 32'(bus.out_y), 32'h1);
      check_val("run4_in_ready_done", 32'(bus.in_ready), 0);

      // Drain in order
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_val("drain_out_y", 32'(bus.out_y), 32'(seq_a[i]));
         tick();
      end
      bus.out_ready = 1'b0;
      check_val("drain_out_valid", 32'(bus.out_valid), 0);
      check_val("drain_level", 32'(level), 0);
      check_val("drain_out_y_zero", 32'(bus.out_y), 0);

      // Overflow: 10 requested, only 8 fit
      pulse_start(8'd10);
      check_val("ovf_run_done", 32'(done), 0);
      check_val("ovf_run_in_ready", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_y = 2'(i);
         tick();
      end
      check_val("full_level", 32'(level), 8);
      check_val("full_in_ready", 32'(bus.in_ready), 0);
      check_val("full_overflow_pre", 32'(overflow), 0);
      bus.in_y = 2'b11;
      tick();
      check_val("ovf_flag", 32'(overflow), 1);
      check_val("ovf_level", 32'(level), 8);
      check_val("ovf_done", 32'(done), 0);

      // Start ignored while capturing
      bus.in_valid = 1'b0;
      pulse_start(8'd0);
      check_val("ign_start_done", 32'(done), 0);
      check_val("ign_start_ovf", 32'(overflow), 1);
      check_val("ign_start_level", 32'(level), 8);

      // Full with simultaneous read and offered write: pop only
      bus.in_valid  = 1'b1;
      bus.in_y      = 2'b11;
      bus.out_ready = 1'b1;
      check_val("full_rw_head", 32'(bus.out_y), 0);
      tick();
      check_val("full_rw_level", 32'(level), 7);
      check_val("full_rw_out_y", 32'(bus.out_y), 1);
      check_val("full_rw_in_ready", 32'(bus.in_ready), 1);
      bus.out_ready = 1'b0;
      tick();
      check_val("refill_level", 32'(level), 8);
      check_val("refill_done", 32'(done), 0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check_val("pop2_level", 32'(level), 7);
      check_val("pop2_out_y", 32'(bus.out_y), 2);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_y      = 2'b01;
      tick();
      bus.in_valid = 1'b0;
      check_val("last_write_level", 32'(level), 8);
      check_val("last_write_done", 32'(done), 1);

      // Zero-length start from DONE; buffer persists
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check_val("pre_len0_level", 32'(level), 7);
      bus.in_valid = 1'b1;
      bus.in_y     = 2'b00;
      pulse_start(8'd0);
      bus.in_valid = 1'b0;
      check_val("len0_done", 32'(done), 1);
      check_val("len0_level", 32'(level), 7);
      check_val("len0_ovf_clr", 32'(overflow), 0);
      check_val("len0_out_y", 32'(bus.out_y), 3);

      // Reset in the middle of a run
      pulse_start(8'd5);
      check_val("mid_run_done", 32'(done), 0);
      bus.in_valid = 1'b1;
      bus.in_y     = 2'b10;
      tick();
      check_val("mid_run_level", 32'(level), 8);
      tick();
      bus.in_valid = 1'b0;
      check_val("mid_run_ovf", 32'(overflow), 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_in_ready", 32'(bus.in_ready), 0);
      check_val("arst_out_valid", 32'(bus.out_valid), 0);
      check_val("arst_level", 32'(level), 0);
      check_val("arst_done", 32'(done), 0);
      check_val("arst_overflow", 32'(overflow), 0);
      check_val("arst_out_y", 32'(bus.out_y), 0);
      #3 rst_n = 1'b1;
      tick();

      // Post-reset run (with comparator when built in)
`ifdef RESP_CAPTURE_CMP_EN
      check_val("cmp_rst", 32'(mismatch_cnt), 0);
`endif
      pulse_start(8'd4);
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_y     = seq_b[i];
`ifdef RESP_CAPTURE_CMP_EN
         exp_y = seq_e[i];
`endif
         tick();
      end
      bus.in_valid = 1'b0;
      check_val("post_rst_level", 32'(level), 4);
      check_val("post_rst_done", 32'(done), 1);
      check_val("post_rst_head", 32'(bus.out_y), 1);
`ifdef RESP_CAPTURE_CMP_EN
      check_val("cmp_cnt", 32'(mismatch_cnt), 2);
      pulse_start(8'd0);
      check_val("cmp_clr", 32'(mismatch_cnt), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
